// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file, one write port, two combinational read ports, pending-write scoreboard
module regfile_2r1w #(
  parameter int data_width = 16,
  parameter int addr_width = 3,
  parameter int bypass_en = 1,
  parameter int zero_r0 = 0,
  localparam int num_regs = 2 ** addr_width
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [addr_width-1:0] writenum,
  input  logic [data_width-1:0] data_in,
  input  logic [addr_width-1:0] readnum0,
  input  logic [addr_width-1:0] readnum1,
  output logic [data_width-1:0] data_out0,
  output logic [data_width-1:0] data_out1,
  input  logic                  reserve,
  input  logic [addr_width-1:0] reservenum,
  output logic                  ready0,
  output logic                  ready1,
  output logic [num_regs-1:0]   pending
);
  logic [data_width-1:0] regs_q [num_regs];
  logic [data_width-1:0] regs_d [num_regs];
  logic [num_regs-1:0] pending_q, pending_d;
  logic wr_ok, rs_ok, byp0, byp1, z0, z1;
  always_comb begin
    wr_ok = write && !(zero_r0 != 0 && writenum == '0);
    rs_ok = reserve && !(zero_r0 != 0 && reservenum == '0);
    regs_d = regs_q;
    pending_d = pending_q;
    if (wr_ok) begin
      regs_d[writenum] = data_in;
      pending_d[writenum] = 1'b0;
    end
    // a new reservation outranks the write retiring the same register
    if (rs_ok) pending_d[reservenum] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pending_q <= '0;
    end else begin
      regs_q <= regs_d;
      pending_q <= pending_d;
    end
  end
  always_comb begin
    z0 = zero_r0 != 0 && readnum0 == '0;
    z1 = zero_r0 != 0 && readnum1 == '0;
    byp0 = bypass_en != 0 && wr_ok && writenum == readnum0;
    byp1 = bypass_en != 0 && wr_ok && writenum == readnum1;
    data_out0 = z0 ? '0 : byp0 ? data_in : regs_q[readnum0];
    data_out1 = z1 ? '0 : byp1 ? data_in : regs_q[readnum1];
    ready0 = z0 ? 1'b1 : byp0 ? !(rs_ok && reservenum == readnum0) : !pending_q[readnum0];
    ready1 = z1 ? 1'b1 : byp1 ? !(rs_ok && reservenum == readnum1) : !pending_q[readnum1];
  end
  assign pending = pending_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed checks of three configurations (bypass, no bypass, zero R0) sharing one stimulus
module tb_regfile_2r1w;
  logic clk = 0, reset, write, reserve;
  logic [2:0] writenum, readnum0, readnum1, reservenum;
  logic [15:0] data_in;
  logic [15:0] a_do0, a_do1, b_do0, b_do1, z_do0, z_do1;
  logic a_r0, a_r1, b_r0, b_r1, z_r0, z_r1;
  logic [7:0] a_p, b_p, z_p;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  regfile_2r1w u_a (.clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum0(readnum0), .readnum1(readnum1), .data_out0(a_do0), .data_out1(a_do1),
    .reserve(reserve), .reservenum(reservenum), .ready0(a_r0), .ready1(a_r1), .pending(a_p));
  regfile_2r1w #(.bypass_en(0)) u_b (.clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum0(readnum0), .readnum1(readnum1), .data_out0(b_do0), .data_out1(b_do1),
    .reserve(reserve), .reservenum(reservenum), .ready0(b_r0), .ready1(b_r1), .pending(b_p));
  regfile_2r1w #(.zero_r0(1)) u_z (.clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum0(readnum0), .readnum1(readnum1), .data_out0(z_do0), .data_out1(z_do1),
    .reserve(reserve), .reservenum(reservenum), .ready0(z_r0), .ready1(z_r1), .pending(z_p));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] n, input logic [15:0] d);
    write = 1; writenum = n; data_in = d;
    step();
    write = 0;
  endtask
  initial begin
    reset = 1; write = 0; reserve = 0; writenum = 0; data_in = 0;
    readnum0 = 0; readnum1 = 0; reservenum = 0;
    step();
    reset = 0; readnum0 = 3; readnum1 = 7; #1;
    chk("rst_do0", 32'(a_do0), 0);
    chk("rst_do1", 32'(a_do1), 0);
    chk("rst_pend", 32'(a_p), 0);
    chk("rst_rdy0", 32'(a_r0), 1);
    chk("rst_rdy1", 32'(a_r1), 1);
    wr(4, 42);
    wr(2, 16'hBEEF);
    readnum0 = 4; readnum1 = 2; #1;
    chk("dual_do0", 32'(a_do0), 42);
    chk("dual_do1", 32'(a_do1), 32'hBEEF);
    readnum1 = 4; #1;
    chk("same_do0", 32'(a_do0), 42);
    chk("same_do1", 32'(a_do1), 42);
    wr(5, 7);
    write = 1; writenum = 5; data_in = 99; readnum0 = 5; #1;
    chk("byp_pre", 32'(a_do0), 99);
    chk("nobyp_pre", 32'(b_do0), 7);
    step();
    write = 0; #1;
    chk("byp_post", 32'(a_do0), 99);
    chk("nobyp_post", 32'(b_do0), 99);
    reserve = 1; reservenum = 3;
    step();
    reserve = 0; readnum0 = 3; #1;
    chk("rsv_pend", 32'(a_p), 32'h08);
    chk("rsv_rdy0", 32'(a_r0), 0);
    step(); step();
    chk("rsv_hold", 32'(a_p), 32'h08);
    write = 1; writenum = 3; data_in = 5; #1;
    chk("wr_byp_rdy", 32'(a_r0), 1);
    chk("wr_nobyp_rdy", 32'(b_r0), 0);
    step();
    write = 0; #1;
    chk("ret_pend", 32'(a_p), 0);
    chk("ret_rdy0", 32'(a_r0), 1);
    chk("ret_do0", 32'(a_do0), 5);
    reserve = 1; reservenum = 3; write = 1; writenum = 3; data_in = 6; #1;
    chk("rsvwr_rdy", 32'(a_r0), 0);
    step();
    reserve = 0; write = 0; #1;
    chk("rsvwr_do0", 32'(a_do0), 6);
    chk("rsvwr_pend", 32'(a_p), 32'h08);
    reserve = 1; reservenum = 6; write = 1; writenum = 3; data_in = 8;
    step();
    reserve = 0; write = 0; #1;
    chk("indep_pend", 32'(a_p), 32'h40);
    chk("indep_do0", 32'(a_do0), 8);
    wr(0, 123);
    readnum0 = 0; #1;
    chk("z_r0_rd", 32'(z_do0), 0);
    chk("nz_r0_rd", 32'(a_do0), 123);
    write = 1; writenum = 0; data_in = 11; #1;
    chk("z_r0_nobyp", 32'(z_do0), 0);
    write = 0;
    reserve = 1; reservenum = 0;
    step();
    reserve = 0; #1;
    chk("z_r0_rsv", 32'(z_p), 32'h40);
    chk("z_r0_rdy", 32'(z_r0), 1);
    chk("nz_r0_rsv", 32'(a_p), 32'h41);
    reserve = 1; reservenum = 1; write = 1; writenum = 1; data_in = 55;
    step();
    reserve = 0; write = 0; readnum0 = 1; #1;
    chk("pre_rst_do0", 32'(a_do0), 55);
    chk("pre_rst_pend", 32'(a_p), 32'h43);
    reset = 1; write = 1; writenum = 1; data_in = 77;
    step();
    reset = 0; write = 0; #1;
    chk("mid_rst_do0", 32'(a_do0), 0);
    chk("mid_rst_pend", 32'(a_p), 0);
    chk("mid_rst_rdy0", 32'(a_r0), 1);
    chk("mid_rst_zpend", 32'(z_p), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor to the single-port 8x16 register file.
- Provides one synchronous write port and two combinational read ports, so a datapath can fetch both ALU operands in the same cycle.
- Adds a synchronous clear, an optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending-write scoreboard for a future pipelined controller.
- Sits between the instruction decoder (register numbers) and the datapath operand latches A/B.

Parameters:
- data_width, 16: bits per register.
- addr_width, 3: register-number width; num_regs = 2**addr_width.
- bypass_en, 1: 1 means a same-cycle write is visible on the read ports (write-through); 0 means reads show stored contents only.
- zero_r0, 0: 1 means R0 always reads 0, writes to R0 are ignored and R0 can never be reserved.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears registers and scoreboard.
- write  input  1  write enable.
- writenum  input  addr_width  destination register.
- data_in  input  data_width  write data.
- readnum0  input  addr_width  read port 0 register.
- readnum1  input  addr_width  read port 1 register.
- data_out0  output  data_width  read port 0 data (combinational).
- data_out1  output  data_width  read port 1 data (combinational).
- reserve  input  1  mark reservenum as pending a future write.
- reservenum  input  addr_width  register to reserve.
- ready0  output  1  1 when readnum0's register is not pending.
- ready1  output  1  1 when readnum1's register is not pending.
- pending  output  num_regs  scoreboard bit vector; bit i is set while register i is reserved.

Behaviour:
- Storage: num_regs x data_width flops. No memory-inference requirement.
- Reset:
  - On posedge clk with reset=1, every register becomes 0 and pending becomes 0.
  - Reset overrides write and reserve in the same cycle.
  - After reset: data_out0/1 = 0, ready0/1 = 1.
- Write: on posedge clk with write=1 and reset=0, reg[writenum] <= data_in. Exception: when zero_r0=1 and writenum=0, nothing is stored.
- Read, base case: data_outN = reg[readnumN], purely combinational, zero latency from readnum change.
- Read, bypass (bypass_en=1): if write=1 and writenum==readnumN (and not the zero_r0 R0 case), data_outN = data_in in the same cycle.
  - Both ports bypass independently.
  - Both ports may read the same register.
- Read, zero_r0=1: readnumN=0 always yields 0, with no bypass.
- Scoreboard, set/clear:
  - On posedge clk, reserve=1 sets pending[reservenum].
  - write=1 clears pending[writenum].
  - Both occur independently when the numbers differ.
- Scoreboard, same register: if reserve and write target the same register in the same cycle, the data is written and the pending bit ends SET (new reservation wins over retiring write).
- Scoreboard, re-reserving: reserving an already-pending register leaves it pending. There is no count; one write clears it.
- Scoreboard, writes without a reservation: writing a non-pending register is legal and leaves pending at 0.
- ready outputs:
  - readyN = ~pending[readnumN], combinational.
  - When bypass_en=1 and the same-cycle write targets readnumN, readyN = 1 (data is being supplied that cycle) unless reserve also targets it.
  - With zero_r0=1, reserve of R0 is ignored and ready for R0 is always 1.
- Illegal or undefined inputs: none. All addr_width codes are valid registers. X on write/reserve is a bench error.

Test Plan:
- Reset then read: assert reset 1 cycle -> data_out0=data_out1=0 for readnum0=3 and readnum1=7; pending=8'h00; ready0=ready1=1.
- Dual write/read: write 42 to R4, then 16'hBEEF to R2 on consecutive edges; readnum0=4, readnum1=2 -> data_out0=42 and data_out1=16'hBEEF the cycle after the second write; readnum0=readnum1=4 -> both 42.
- Bypass: bypass_en=1, R5 holds 7, write=1 writenum=5 data_in=99, readnum0=5 -> data_out0=99 before the edge and stays 99 after it. Repeat with bypass_en=0 -> 7 before the edge, 99 after.
- Scoreboard: reserve R3 -> pending=8'h08 and ready0=0 for readnum0=3; 2 idle cycles stay pending; write R3=5 -> pending=0 and ready0=1. Simultaneous reserve R3 and write R3=6 -> R3=6 and pending[3]=1.
- zero_r0=1: write R0=123 -> data_out0=0 for readnum0=0; reserve R0 -> pending[0]=0.
- Reset mid-operation: R1=55 and pending[1]=1, then reset together with write R1=77 -> R1=0, pending=0, data_out0=0 for readnum0=1.
